// File: rtl/msrv32_pkg.sv
// Shared immediate-type codes and sign-extension helper for the
// decode-stage immediate generator.
package msrv32_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_I1  = 3'b001;
    localparam logic [2:0] IMM_S   = 3'b010;
    localparam logic [2:0] IMM_B   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_J   = 3'b101;
    localparam logic [2:0] IMM_CSR = 3'b110;
    localparam logic [2:0] IMM_I7  = 3'b111;

    // Callers truncate the 64-bit result to XLEN.
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/msrv32_imm_decode.sv
// Combinational immediate decode: instruction bits [31:7] plus type
// code to an XLEN-wide immediate and an illegal-type flag.
module msrv32_imm_decode
    import msrv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     i_instr,
    input  logic [2:0]      i_type,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    // i_instr[k] holds instruction bit k+7.
    logic [63:0] w_full;

    always_comb begin
        w_full    = '0;
        o_illegal = 1'b0;
        case (i_type)
            IMM_S:   w_full = sext32({{20{i_instr[24]}},
                                      i_instr[24:18], i_instr[4:0]});
            IMM_B:   w_full = sext32({{19{i_instr[24]}}, i_instr[24],
                                      i_instr[0], i_instr[23:18],
                                      i_instr[4:1], 1'b0});
            IMM_U:   w_full = sext32({i_instr[24:5], 12'h000});
            IMM_J:   w_full = sext32({{11{i_instr[24]}}, i_instr[24],
                                      i_instr[12:5], i_instr[13],
                                      i_instr[23:14], 1'b0});
            IMM_CSR: w_full = {59'd0, i_instr[12:8]};
            IMM_I1: begin
                if (XLEN == 64) begin
                    w_full    = {58'd0, i_instr[18:13]};
                    o_illegal = |i_instr[24:19];
                end else begin
                    w_full = sext32({{20{i_instr[24]}}, i_instr[24:13]});
                end
            end
            default: w_full = sext32({{20{i_instr[24]}}, i_instr[24:13]});
        endcase
    end

    assign o_imm = w_full[XLEN-1:0];

endmodule

// File: rtl/msrv32_imm_gen_pipe.sv
// Registered immediate generator with a one-entry output stage and a
// one-entry skid buffer behind a valid/ready handshake.
module msrv32_imm_gen_pipe
    import msrv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             flush_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [24:0]      instr_in,
    input  logic [2:0]       imm_type_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal_out
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("msrv32_imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  w_imm;
    logic             w_ill;
    logic             w_accept;
    logic             w_out_free;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_imm;
    logic [TAG_W-1:0] r_tag;
    logic             r_ill;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_ill;

    msrv32_imm_decode #(.XLEN(XLEN)) u_dec (
        .i_instr   (instr_in),
        .i_type    (imm_type_in),
        .o_imm     (w_imm),
        .o_illegal (w_ill)
    );

    // Ready depends only on the skid register, never on out_ready_in.
    assign in_ready_out = ~r_skid_valid;
    assign w_accept     = in_valid_in & ~r_skid_valid;
    assign w_out_free   = ~r_out_valid | out_ready_in;

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_out_valid  <= 1'b0;
            r_imm        <= '0;
            r_tag        <= '0;
            r_ill        <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_tag   <= '0;
            r_skid_ill   <= 1'b0;
        end else if (flush_in) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_imm        <= r_skid_imm;
                r_tag        <= r_skid_tag;
                r_ill        <= r_skid_ill;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_imm       <= w_imm;
                r_tag       <= tag_in;
                r_ill       <= w_ill;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm;
            r_skid_tag   <= tag_in;
            r_skid_ill   <= w_ill;
        end
    end

    assign out_valid_out = r_out_valid;
    assign imm_out       = r_imm;
    assign tag_out       = r_tag;
    assign illegal_out   = r_ill;

endmodule
